// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: single-port 32-bit data memory for the picoLoongArch load/store path.
// Byte/half/word loads and stores with per-lane writes and signed/unsigned load
// extension. Load results are registered (one cycle after acceptance). After reset
// a clear sequence zeroes the array and writes the boot value 'num' into word 0.
// Optional build macro: DATA_RAM_ALIGN_CHK_EN
//   defined   -> misaligned half/word requests are dropped and pulse err
//   undefined -> half/word accesses are forced to natural alignment, err stays 0
module data_ram_ctrl #(
    parameter int DEPTH_LOG2 = 8,
    parameter int INIT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INIT_W-1:0] num,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    // Registered state
    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] clr_ptr_q, clr_ptr_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;

    // Storage array; not reset, the clear sequence initialises it
    logic [31:0] mem [DEPTH];

    // Memory write port controls
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;

    // Access decode
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [1:0]            eff_off;
    logic                  misalign;
    logic [3:0]            acc_strb;
    logic [31:0]           lane_wdata;
    logic [31:0]           rd_word;
    logic [31:0]           rd_shift;
    logic [31:0]           load_val;
    logic [31:0]           num_ext;
    logic                  accept;

    // Address bits above the array wrap and are deliberately ignored
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

    // Zero-extend the boot value to a full word
    always_comb begin
        num_ext              = '0;
        num_ext[INIT_W-1:0]  = num;
    end

    // Lane offset and alignment handling
    always_comb begin
        acc_idx = addr[DEPTH_LOG2+1:2];
`ifdef DATA_RAM_ALIGN_CHK_EN
        misalign = ((size == 2'd1) && addr[0]) ||
                   (size[1] && (addr[1:0] != 2'b00));
        eff_off  = addr[1:0];
`else
        misalign = 1'b0;
        case (size)
            2'd0:    eff_off = addr[1:0];
            2'd1:    eff_off = {addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
`endif
    end

    // Store lane strobes and lane-replicated store data
    always_comb begin
        case (size)
            2'd0: begin
                acc_strb   = 4'b0001 << eff_off;
                lane_wdata = {4{wdata[7:0]}};
            end
            2'd1: begin
                acc_strb   = eff_off[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
            end
            default: begin
                acc_strb   = 4'b1111;
                lane_wdata = wdata;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        rd_word  = mem[acc_idx];
        rd_shift = rd_word >> {eff_off, 3'b000};
        case (size)
            2'd0:    load_val = {{24{sext & rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    load_val = {{16{sext & rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_shift;
        endcase
    end

    assign accept = req && (state_q == ST_IDLE);

    // Next-state, clear sequencing and access handling
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = acc_idx;
        mem_wdata = lane_wdata;
        mem_wstrb = acc_strb;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_idx   = clr_ptr_q;
                mem_wdata = (clr_ptr_q == '0) ? num_ext : '0;
                mem_wstrb = 4'b1111;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (&clr_ptr_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    if (misalign) begin
                        err_d = 1'b1;
                    end else if (we) begin
                        mem_we = 1'b1;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = load_val;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    // Byte-lane memory write; suppressed while reset is held
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mem_wstrb[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ready  = (state_q == ST_IDLE);
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard testbench for data_ram_ctrl: stimulus pushes expected load results
// and error pulses (with the expected cycle) into queues; a monitor pops and
// compares whenever rvalid or err is seen.
module tb_data_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] num;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] exp_data[$];
    int          exp_cyc[$];
    string       exp_name[$];
    int          err_cyc[$];
    string       err_name[$];
    logic [31:0] last_rdata;

    data_ram_ctrl #(.DEPTH_LOG2(8), .INIT_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .num    (num),
        .req    (req),
        .we     (we),
        .size   (size),
        .sext   (sext),
        .addr   (addr),
        .wdata  (wdata),
        .ready  (ready),
        .rdata  (rdata),
        .rvalid (rvalid),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: results must appear in the cycle directly after the accepting edge
    always @(negedge clk) begin
        if (rvalid) begin
            checks++;
            if (exp_data.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: rdata=%h at cycle %0d, required no result", rdata, cyc);
            end else begin
                logic [31:0] d;
                int c;
                string n;
                d = exp_data.pop_front();
                c = exp_cyc.pop_front();
                n = exp_name.pop_front();
                if (rdata !== d || cyc != c) begin
                    errors++;
                    $display("FAIL %s: rdata=%h cycle=%0d, required rdata=%h cycle=%0d", n, rdata, cyc, d, c);
                end
            end
        end
        if (err) begin
            checks++;
            if (err_cyc.size() == 0) begin
                errors++;
                $display("FAIL unexpected_err: err=1 at cycle %0d, required err=0", cyc);
            end else begin
                int c;
                string n;
                c = err_cyc.pop_front();
                n = err_name.pop_front();
                if (cyc != c) begin
                    errors++;
                    $display("FAIL %s: err at cycle %0d, required cycle %0d", n, cyc, c);
                end
            end
        end
    end

    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input bit exp_err, input string nm);
        req   = 1'b1;
        we    = w;
        size  = sz;
        sext  = sx;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        if (exp_err) begin
            err_cyc.push_back(cyc);
            err_name.push_back(nm);
        end else if (!w) begin
            exp_data.push_back(exp);
            exp_cyc.push_back(cyc);
            exp_name.push_back(nm);
            last_rdata = exp;
        end
        req = 1'b0;
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        access(1'b1, sz, 1'b0, a, d, 32'h0, 1'b0, "store");
    endtask

    task automatic load(input logic [1:0] sz, input logic sx, input logic [31:0] a,
                        input logic [31:0] exp, input string nm);
        access(1'b0, sz, sx, a, 32'h0, exp, 1'b0, nm);
    endtask

    // Counts cycles after reset release until ready rises, bounded
    task automatic wait_clear(input string nm);
        int n;
        n = 0;
        while (!ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 256 || !ready) begin
            errors++;
            $display("FAIL %s: ready after %0d cycles (ready=%b), required 256", nm, n, ready);
        end
    endtask

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    initial begin
        int bad;
        rst   = 1'b1;
        num   = 32'h0000005A;
        req   = 1'b0;
        we    = 1'b0;
        size  = 2'd0;
        sext  = 1'b0;
        addr  = '0;
        wdata = '0;
        last_rdata = '0;

        // Reset and clear
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_ready",  {31'b0, ready},  32'h0);
        check_val("reset_rvalid", {31'b0, rvalid}, 32'h0);
        check_val("reset_rdata",  rdata,           32'h0);
        check_val("reset_err",    {31'b0, err},    32'h0);
        rst = 1'b0;
        wait_clear("clear_len");

        load(2'd2, 1'b0, 32'h0,   32'h0000005A, "boot_word0");
        load(2'd2, 1'b0, 32'h3FC, 32'h00000000, "clear_last");

        // Byte and half lanes, load right after store
        store(2'd2, 32'h10, 32'h11223344);
        store(2'd0, 32'h12, 32'h000000AB);
        load(2'd2, 1'b0, 32'h10, 32'h11AB3344, "byte_lane");
        store(2'd1, 32'h12, 32'h0000CAFE);
        load(2'd2, 1'b0, 32'h10, 32'hCAFE3344, "half_lane");

        // Extension
        store(2'd2, 32'h20, 32'h0080FF7F);
        load(2'd0, 1'b1, 32'h20, 32'h0000007F, "ldb_20");
        load(2'd0, 1'b1, 32'h21, 32'hFFFFFFFF, "ldb_21");
        load(2'd0, 1'b0, 32'h21, 32'h000000FF, "ldbu_21");
        load(2'd1, 1'b1, 32'h22, 32'h00000080, "ldh_22");
        load(2'd1, 1'b0, 32'h20, 32'h0000FF7F, "ldhu_20");
        load(2'd1, 1'b1, 32'h20, 32'hFFFFFF7F, "ldh_20");
        load(2'd3, 1'b1, 32'h20, 32'h0080FF7F, "size3_word");

        // Wrap, then back-to-back loads
        store(2'd2, 32'h400, 32'hDEADBEEF);
        load(2'd2, 1'b0, 32'h0,   32'hDEADBEEF, "b2b_0");
        load(2'd2, 1'b0, 32'h10,  32'hCAFE3344, "b2b_1");
        load(2'd2, 1'b0, 32'h20,  32'h0080FF7F, "b2b_2");
        load(2'd2, 1'b0, 32'h3FC, 32'h00000000, "b2b_3");
        repeat (3) @(posedge clk);
        #1;
        check_val("rdata_hold", rdata, last_rdata);

        // Alignment
`ifdef DATA_RAM_ALIGN_CHK_EN
        access(1'b1, 2'd2, 1'b0, 32'h41, 32'h12345678, 32'h0, 1'b1, "misalign_store");
        load(2'd2, 1'b0, 32'h40, 32'h00000000, "misalign_nowrite");
        access(1'b0, 2'd1, 1'b0, 32'h23, 32'h0, 32'h0, 1'b1, "misalign_load");
        repeat (2) @(posedge clk);
        #1;
        check_val("misalign_rdata_hold", rdata, 32'h00000000);
`else
        store(2'd2, 32'h41, 32'h12345678);
        load(2'd2, 1'b0, 32'h40, 32'h12345678, "forced_align_word");
        load(2'd1, 1'b0, 32'h23, 32'h00000080, "forced_align_half");
`endif

        // Reset mid-clear; a load presented with rst high must be ignored
        repeat (2) @(posedge clk);
        #1;
        num  = 32'h000000C3;
        rst  = 1'b1;
        req  = 1'b1;
        we   = 1'b0;
        size = 2'd2;
        addr = 32'h10;
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (ready) bad++;
        end
        check_val("midclear_ready_low", bad, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clear("midclear_len");
        load(2'd2, 1'b0, 32'h0,  32'h000000C3, "reclear_word0");
        load(2'd2, 1'b0, 32'h10, 32'h00000000, "reclear_10");
        load(2'd2, 1'b0, 32'h40, 32'h00000000, "reclear_40");

        repeat (4) @(posedge clk);
        #1;
        check_val("missing_results", exp_data.size(), 0);
        check_val("missing_err",     err_cyc.size(),  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
